// File: rtl/rams_sdp_bwe_clr.sv
// Simple dual-port RAM: byte-enabled write port A, pipelined read port B, and a reset-driven
// clear sweep that rebuilds the preset image. Define RAMS_SDP_BYPASS_EN for write-first reads.
module rams_sdp_bwe_clr #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 10,
  parameter int unsigned           DATA_DEPTH   = 1024,
  parameter int unsigned           READ_LATENCY = 1,
  parameter int unsigned           INIT_A_ADDR  = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_A_VAL   = 32'h40000000,
  parameter int unsigned           INIT_B_ADDR  = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_B_VAL   = 32'h10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dia,
  input  logic                    enb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   dob,
  output logic                    dob_valid,
  output logic                    busy
);

  localparam int unsigned           NumBytes  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DepthW    = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] InitAAddr = ADDR_WIDTH'(INIT_A_ADDR);
  localparam logic [ADDR_WIDTH-1:0] InitBAddr = ADDR_WIDTH'(INIT_B_ADDR);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   clr_word;

  logic [DATA_WIDTH-1:0]   ram [DATA_DEPTH];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic [NumBytes-1:0]     mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    rd_valid1;
  logic [DATA_WIDTH-1:0]   rd_data1;

  assign wr_in_range = {1'b0, addra} < DepthW;
  assign rd_in_range = {1'b0, addrb} < DepthW;

  // Sweep controller; busy is registered so it drops on the edge after the last clear write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StClear;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      unique case (state)
        StClear: begin
          if (clr_addr == LastAddr) begin
            state <= StRun;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        StRun: begin
        end
      endcase
    end
  end

  always_comb begin
    clr_word = '0;
    if (clr_addr == InitAAddr) begin
      clr_word = INIT_A_VAL;
    end else if (clr_addr == InitBAddr) begin
      clr_word = INIT_B_VAL;
    end
  end

  // Single physical write port shared by the sweep and port A.
  always_comb begin
    mem_we    = '0;
    mem_addr  = addra;
    mem_wdata = dia;
    if (!rst) begin
      if (state == StClear) begin
        mem_we    = '1;
        mem_addr  = clr_addr;
        mem_wdata = clr_word;
      end else if (ena && wr_in_range) begin
        mem_we = wea;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (mem_we[i]) begin
        ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = ram[addrb];
`ifdef RAMS_SDP_BYPASS_EN
      // Forward the bytes being written this cycle so a colliding read sees the new word.
      if (state == StRun && mem_addr == addrb) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (mem_we[i]) begin
            rd_word[8*i +: 8] = dia[8*i +: 8];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid1 <= 1'b0;
      rd_data1  <= '0;
    end else begin
      rd_valid1 <= enb && (state == StRun);
      if (enb && (state == StRun)) begin
        rd_data1 <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd_valid2;
    logic [DATA_WIDTH-1:0] rd_data2;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid2 <= 1'b0;
        rd_data2  <= '0;
      end else begin
        rd_valid2 <= rd_valid1;
        if (rd_valid1) begin
          rd_data2 <= rd_data1;
        end
      end
    end

    assign dob       = rd_data2;
    assign dob_valid = rd_valid2;
  end else begin : g_lat1
    assign dob       = rd_data1;
    assign dob_valid = rd_valid1;
  end

endmodule
